vga_fb_reader: RTL and testbench
================================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameters: H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48; V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33; IMG_W 512, IMG_H 256, X_OFF 64, Y_OFF 112 (image window); BORDER 8'h00 (grey level shown outside the window).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  25 MHz pixel clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  scan enable.
- rdata  in  8  video-memory read data, valid 1 cycle after raddr/re are sampled.
- raddr  out  17  video-memory read address, {row[7:0], col[8:0]}.
- re  out  1  read enable.
- pixel  out  8  grey pixel to the DAC.
- blank_n  out  1  high during the visible region.
- hsync_n, vsync_n  out  1  active-low sync signals.
- frame_start  out  1  one-cycle pulse, aligned with pixel (0,0) on the outputs.

Function
REQ-004 SHALL keep internal counters h_cnt in 0..799 and v_cnt in 0..524; h_cnt increments every cycle while en=1.
REQ-005 SHALL wrap h_cnt from 799 to 0 and increment v_cnt in the same cycle; SHALL wrap v_cnt from 524 to 0 when h_cnt wraps.
REQ-006 SHALL force both counters to 0 while en=0; the first cycle with en=1 processes position (0,0).
REQ-007 SHALL define a position as visible when h_cnt<640 and v_cnt<480.
REQ-008 SHALL define hsync active when 656<=h_cnt<=751 and vsync active when 490<=v_cnt<=491.
REQ-009 SHALL define a position as in-window when 64<=h_cnt<=575 and 112<=v_cnt<=367.
REQ-010 Stage 1: SHALL register re=in-window and raddr={v_cnt-Y_OFF[7:0], h_cnt-X_OFF[8:0]} when in-window; otherwise re=0 and raddr=0.
REQ-011 Stage 2: SHALL register the window, visible, hsync, vsync and (0,0) flags alongside the memory access.
REQ-012 Stage 3: SHALL register pixel=rdata if the window flag is set, BORDER if visible but not in-window, and 0 if not visible.
REQ-013 SHALL register blank_n, hsync_n, vsync_n and frame_start in stage 3.
REQ-014 SHALL align every output so a counter position at cycle t appears on pixel, blank_n, sync and frame_start at cycle t+3, and on raddr/re at cycle t+1.
REQ-015 SHALL produce exactly 512 re-high cycles per line for each of the 256 window lines (131072 reads/frame); raddr SHALL walk 0..131071 in order and never exceed 17'h1FFFF.
REQ-016 SHALL flush the pipeline when en falls: stage registers take their reset values on the next cycle.
REQ-017 SHALL NOT stall or backpressure; rdata is assumed valid exactly one cycle after re.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, set h_cnt=0, v_cnt=0, raddr=0, re=0, pixel=0, blank_n=0, hsync_n=1, vsync_n=1, frame_start=0, and clear all pipeline flags.
REQ-019 SHALL let rst override en; a mid-frame reset restarts at (0,0) on the first cycle after rst falls with en=1.

Verification
REQ-020 Reset then en=1: frame_start on cycle 3; blank_n=1 for 640 cycles per line; hsync_n low for 96 cycles starting 656 cycles after line start; line period 800.
REQ-021 Frame timing: vsync_n low for lines 490-491 (1600 cycles); frame_start period is 420000 cycles.
REQ-022 Memory model returning rdata=raddr[7:0]: first re at line 112, h=64 with raddr=0; pixel at that position =8'h00 three cycles later; line 113 starts at raddr=512; last read is raddr=131071.
REQ-023 BORDER=8'h40: a visible pixel at h=10, v=10 outputs 8'h40; h=700 outputs 0 with blank_n=0.
REQ-024 rst asserted at v=200, h=300: outputs take reset values next cycle; after release, frame_start arrives at cycle 3 and raddr restarts from 0 at line 112.
REQ-025 en dropped mid-line, then raised: outputs go idle the next cycle (re=0, blank_n=0, syncs high); on re-enable, timing matches a fresh start.

Source files
------------

// File: rtl/vga_fb_reader.sv
// VGA 640x480 raster generator that fetches a grey image window from video memory.
// A position takes three registered stages: read request, memory latency, output.
module vga_fb_reader #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned X_OFF  = 64,
  parameter int unsigned Y_OFF  = 112,
  parameter logic [7:0]  BORDER = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  rdata,
  output logic [16:0] raddr,
  output logic        re,
  output logic [7:0]  pixel,
  output logic        blank_n,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;
  // Counters are never narrower than the column/row address fields they feed.
  localparam int unsigned HW = ($clog2(HTot) > 9) ? $clog2(HTot) : 9;
  localparam int unsigned VW = ($clog2(VTot) > 8) ? $clog2(VTot) : 8;

  localparam logic [HW-1:0] HMax  = HW'(HTot - 1);
  localparam logic [VW-1:0] VMax  = VW'(VTot - 1);
  localparam logic [HW-1:0] HVis  = HW'(H_VIS);
  localparam logic [VW-1:0] VVis  = VW'(V_VIS);
  localparam logic [HW-1:0] HsBeg = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HsEnd = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VsBeg = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VsEnd = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] XBeg  = HW'(X_OFF);
  localparam logic [HW-1:0] XEnd  = HW'(X_OFF + IMG_W - 1);
  localparam logic [VW-1:0] YBeg  = VW'(Y_OFF);
  localparam logic [VW-1:0] YEnd  = VW'(Y_OFF + IMG_H - 1);
  localparam logic [8:0]    XCol  = 9'(X_OFF);
  localparam logic [7:0]    YRow  = 8'(Y_OFF);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          clr;
  logic          vis, hs, vs, win, origin;
  logic [8:0]    col;
  logic [7:0]    row;

  // Stage-1 side flags (re itself is the stage-1 window flag).
  logic s1_vis_q, s1_hs_q, s1_vs_q, s1_org_q;
  // Stage-2 flags, aligned with rdata.
  logic s2_win_q, s2_vis_q, s2_hs_q, s2_vs_q, s2_org_q;

  // Reset and a low enable both hold counters at the origin and empty the pipeline.
  assign clr = rst | ~en;

  // Raster position advance with line and frame wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HMax) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Region decode of the current position and its image-relative address.
  always_comb begin
    vis    = (h_cnt_q < HVis) && (v_cnt_q < VVis);
    hs     = (h_cnt_q >= HsBeg) && (h_cnt_q <= HsEnd);
    vs     = (v_cnt_q >= VsBeg) && (v_cnt_q <= VsEnd);
    win    = (h_cnt_q >= XBeg) && (h_cnt_q <= XEnd) && (v_cnt_q >= YBeg) && (v_cnt_q <= YEnd);
    origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    // Only the low address bits matter, so subtract in the narrow field width.
    col    = h_cnt_q[8:0] - XCol;
    row    = v_cnt_q[7:0] - YRow;
  end

  // Stage 1: memory read request plus position flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      re       <= 1'b0;
      raddr    <= '0;
      s1_vis_q <= 1'b0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_org_q <= 1'b0;
    end else begin
      re       <= win;
      raddr    <= win ? {row, col} : 17'h0;
      s1_vis_q <= vis;
      s1_hs_q  <= hs;
      s1_vs_q  <= vs;
      s1_org_q <= origin;
    end
  end

  // Stage 2: carry flags while the memory returns rdata.
  always_ff @(posedge clk) begin
    if (clr) begin
      s2_win_q <= 1'b0;
      s2_vis_q <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s2_org_q <= 1'b0;
    end else begin
      s2_win_q <= re;
      s2_vis_q <= s1_vis_q;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_org_q <= s1_org_q;
    end
  end

  // Stage 3: select image, border or black and register the timing outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      pixel       <= 8'h00;
      blank_n     <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (s2_win_q) begin
        pixel <= rdata;
      end else if (s2_vis_q) begin
        pixel <= BORDER;
      end else begin
        pixel <= 8'h00;
      end
      blank_n     <= s2_vis_q;
      hsync_n     <= ~s2_hs_q;
      vsync_n     <= ~s2_vs_q;
      frame_start <= s2_org_q;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: a compact-timing instance checked every cycle against a
// position-based model, and a default-timing instance checked on its first lines.
module tb_vga_fb_reader;

  // Compact raster: 536 x 16 positions, 512x4 window at (4,3), border grey 0x40.
  localparam int SHVis = 520, SHFp = 4, SHSync = 8, SHBp = 4;
  localparam int SVVis = 10, SVFp = 2, SVSync = 2, SVBp = 2;
  localparam int SImgW = 512, SImgH = 4, SXOff = 4, SYOff = 3;
  localparam int SHt = SHVis + SHFp + SHSync + SHBp;
  localparam int SVt = SVVis + SVFp + SVSync + SVBp;
  localparam int SFrame = SHt * SVt;
  localparam logic [7:0] SBorder = 8'h40;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  rdata_s, rdata_d;
  logic [16:0] raddr_s, raddr_d;
  logic        re_s, re_d, blank_s, blank_d, hs_s, hs_d, vs_s, vs_d, fs_s, fs_d;
  logic [7:0]  pixel_s, pixel_d;

  int n_chk = 0;
  int n_fail = 0;

  always #20 clk = ~clk;

  vga_fb_reader #(
    .H_VIS(SHVis), .H_FP(SHFp), .H_SYNC(SHSync), .H_BP(SHBp),
    .V_VIS(SVVis), .V_FP(SVFp), .V_SYNC(SVSync), .V_BP(SVBp),
    .IMG_W(SImgW), .IMG_H(SImgH), .X_OFF(SXOff), .Y_OFF(SYOff), .BORDER(SBorder)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .rdata(rdata_s), .raddr(raddr_s), .re(re_s),
    .pixel(pixel_s), .blank_n(blank_s), .hsync_n(hs_s), .vsync_n(vs_s), .frame_start(fs_s)
  );

  vga_fb_reader dut_d (
    .clk(clk), .rst(rst), .en(en), .rdata(rdata_d), .raddr(raddr_d), .re(re_d),
    .pixel(pixel_d), .blank_n(blank_d), .hsync_n(hs_d), .vsync_n(vs_d), .frame_start(fs_d)
  );

  // Video memories: one-cycle latency, data = low address byte, 0xEE when not read.
  always @(posedge clk) begin
    rdata_s <= re_s ? raddr_s[7:0] : 8'hEE;
    rdata_d <= re_d ? raddr_d[7:0] : 8'hEE;
  end

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp,
               exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit s_in_win(int h, int v);
    return h >= SXOff && h < SXOff + SImgW && v >= SYOff && v < SYOff + SImgH;
  endfunction

  function automatic bit s_in_vis(int h, int v);
    return h < SHVis && v < SVVis;
  endfunction

  // Model: cycles since the last (re)start give the raster position; an output shows
  // the position from three cycles ago only if every edge since then was enabled.
  int  mk = 0;
  bit  armed = 1'b0;
  bit  e_ok [3];
  int  e_h [3];
  int  e_v [3];

  always @(posedge clk) begin : model
    bit ok, v3, win0, win3, vis3, hs3, vs3, org3;
    int h, v, ra_x, pix_x;
    ok = en && !rst;
    if (rst) armed = 1'b1;
    for (int i = 2; i > 0; i--) begin
      e_ok[i] = e_ok[i-1];
      e_h[i]  = e_h[i-1];
      e_v[i]  = e_v[i-1];
    end
    e_ok[0] = ok;
    e_h[0]  = mk % SHt;
    e_v[0]  = mk / SHt;
    mk = ok ? (mk + 1) % SFrame : 0;
    #1;
    if (armed) begin
      win0 = e_ok[0] && s_in_win(e_h[0], e_v[0]);
      ra_x = win0 ? (e_v[0] - SYOff) * 512 + (e_h[0] - SXOff) : 0;
      h    = e_h[2];
      v    = e_v[2];
      v3   = e_ok[0] && e_ok[1] && e_ok[2];
      win3 = v3 && s_in_win(h, v);
      vis3 = v3 && s_in_vis(h, v);
      hs3  = v3 && h >= SHVis + SHFp && h < SHVis + SHFp + SHSync;
      vs3  = v3 && v >= SVVis + SVFp && v < SVVis + SVFp + SVSync;
      org3 = v3 && h == 0 && v == 0;
      pix_x = win3 ? ((h - SXOff) & 255) : (vis3 ? int'(SBorder) : 0);
      chk_b("re", re_s, win0);
      chk_v("raddr", 32'(raddr_s), ra_x);
      chk_v("pixel", 32'(pixel_s), pix_x);
      chk_b("blank_n", blank_s, vis3);
      chk_b("hsync_n", hs_s, !hs3);
      chk_b("vsync_n", vs_s, !vs3);
      chk_b("frame_start", fs_s, org3);
    end
  end

  task automatic idle_check(input string tag);
    chk_v({tag, "_pixel"}, 32'(pixel_s), 0);
    chk_b({tag, "_blank_n"}, blank_s, 1'b0);
    chk_b({tag, "_hsync_n"}, hs_s, 1'b1);
    chk_b({tag, "_vsync_n"}, vs_s, 1'b1);
    chk_b({tag, "_frame_start"}, fs_s, 1'b0);
    chk_b({tag, "_re"}, re_s, 1'b0);
    chk_v({tag, "_raddr"}, 32'(raddr_s), 0);
    chk_b({tag, "_d_blank_n"}, blank_d, 1'b0);
    chk_b({tag, "_d_re"}, re_d, 1'b0);
  endtask

  int d_blank = 0, d_hs_low = 0, d_fall1 = -1, d_fall2 = -1, d_re = 0;
  bit d_hs_prev = 1'b1;
  int s_fs1 = -1, s_fs2 = -1, s_reads = 0, s_last = -1, s_max = 0, s_vs_low = 0;
  int s_first_re = -1, s_first_addr = -1;
  int r_first_re, r_first_addr;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_check("reset");
    rst = 1'b0;
    en  = 1'b1;

    // Free-running frame; cycle 0 processes (0,0).
    for (int n = 1; n <= SFrame + 2980; n++) begin
      @(posedge clk);
      #1;
      if (n <= 2403) begin
        if (n <= 3) chk_b("d_frame_start_start", fs_d, n == 3);
        if (n >= 3 && n <= 802) begin
          if (blank_d) d_blank++;
          if (!hs_d) d_hs_low++;
        end
        if (!hs_d && d_hs_prev) begin
          if (d_fall1 < 0) d_fall1 = n;
          else if (d_fall2 < 0) d_fall2 = n;
        end
        d_hs_prev = hs_d;
        if (re_d) d_re++;
      end
      if (fs_s) begin
        if (s_fs1 < 0) s_fs1 = n;
        else if (s_fs2 < 0) s_fs2 = n;
      end
      if (n <= SFrame && re_s) begin
        s_reads++;
        s_last = int'(raddr_s);
        if (int'(raddr_s) > s_max) s_max = int'(raddr_s);
      end
      if (n <= SFrame && !vs_s) s_vs_low++;
      if (re_s && s_first_re < 0) begin
        s_first_re   = n;
        s_first_addr = int'(raddr_s);
      end
      if (n == 540) begin
        chk_v("s_border_pixel", 32'(pixel_s), 32'h40);
        chk_b("s_border_blank_n", blank_s, 1'b1);
      end
      if (n == 1064) begin
        chk_v("s_hblank_pixel", 32'(pixel_s), 0);
        chk_b("s_hblank_blank_n", blank_s, 1'b0);
        chk_b("s_hblank_hsync_n", hs_s, 1'b0);
      end
      if (n == 1615) chk_v("s_first_window_pixel", 32'(pixel_s), 0);
      if (n == 1652) chk_v("s_window_pixel_col37", 32'(pixel_s), 32'h25);
      if (n == 2149) chk_v("s_line1_first_raddr", 32'(raddr_s), 512);
    end
    chk_v("d_blank_cycles_line0", d_blank, 640);
    chk_v("d_hsync_low_cycles_line0", d_hs_low, 96);
    chk_v("d_hsync_first_fall", d_fall1, 659);
    chk_v("d_line_period", d_fall2 - d_fall1, 800);
    chk_v("d_no_reads_top_lines", d_re, 0);
    chk_v("s_frame_start_first", s_fs1, 3);
    chk_v("s_frame_period", s_fs2 - s_fs1, SFrame);
    chk_v("s_reads_per_frame", s_reads, 2048);
    chk_v("s_last_read_addr", s_last, 2047);
    chk_v("s_max_read_addr", s_max, 2047);
    chk_v("s_vsync_low_cycles", s_vs_low, 2 * SHt);
    chk_v("s_first_read_cycle", s_first_re, 1613);
    chk_v("s_first_read_addr", s_first_addr, 0);

    // Mid-frame reset while processing v=5, h=300 with en still high.
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_check("midrst");
    rst = 1'b0;
    r_first_re = -1;
    r_first_addr = -1;
    for (int n = 1; n <= 1620; n++) begin
      @(posedge clk);
      #1;
      if (n <= 3) chk_b("midrst_frame_start", fs_s, n == 3);
      if (re_s && r_first_re < 0) begin
        r_first_re   = n;
        r_first_addr = int'(raddr_s);
      end
    end
    chk_v("midrst_first_read_cycle", r_first_re, 1613);
    chk_v("midrst_first_read_addr", r_first_addr, 0);

    // Enable dropped inside a window line, then raised again.
    en = 1'b0;
    @(posedge clk);
    #1;
    idle_check("endrop");
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
    r_first_re = -1;
    r_first_addr = -1;
    for (int n = 1; n <= SFrame + 124; n++) begin
      @(posedge clk);
      #1;
      if (n <= 3) chk_b("reen_frame_start", fs_s, n == 3);
      if (n == SFrame + 3) chk_b("reen_frame_start_next", fs_s, 1'b1);
      if (re_s && r_first_re < 0) begin
        r_first_re   = n;
        r_first_addr = int'(raddr_s);
      end
    end
    chk_v("reen_first_read_cycle", r_first_re, 1613);
    chk_v("reen_first_read_addr", r_first_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
